// File: rtl/ltl_report_collector.sv
// Timestamps non-zero automaton report vectors with their symbol offset and queues them for a valid/ready consumer.
// Optional feature: define LTL_REPORT_DEDUP_EN to collapse runs of identical report vectors into their first entry.
module ltl_report_collector #(
  parameter int N_REPORTS  = 4,
  parameter int OFFSET_W   = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [N_REPORTS-1:0] report_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OFFSET_W-1:0]  out_offset,
  output logic [N_REPORTS-1:0] out_vector,
  output logic                 overflow,
  output logic [DROP_W-1:0]    drop_count,
  input  logic                 clear_status
);

  localparam int IDX_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = OFFSET_W + N_REPORTS;
  localparam logic [OFFSET_W-1:0] OFF_ONE  = OFFSET_W'(1'b1);
  localparam logic [IDX_W:0]      PTR_ONE  = (IDX_W + 1)'(1'b1);
  localparam logic [DROP_W-1:0]   DROP_ONE = DROP_W'(1'b1);
  localparam logic [DROP_W-1:0]   DROP_MAX = {DROP_W{1'b1}};

  logic [OFFSET_W-1:0] sym_off_q, sym_off_d;
  logic                run_dly_q, run_dly_d;
  logic [OFFSET_W-1:0] off_dly_q, off_dly_d;
  logic [IDX_W:0]      wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]      rd_ptr_q, rd_ptr_d;
  logic                overflow_q, overflow_d;
  logic [DROP_W-1:0]   drop_count_q, drop_count_d;
  logic [ENTRY_W-1:0]  mem_q [FIFO_DEPTH];

  logic capture_s, suppress_s, push_req_s, push_s, pop_s, drop_s;
  logic full_s, empty_s;
  logic [ENTRY_W-1:0] head_s;

  // Report lines lag the automaton by one symbol, so they pair with the delayed offset.
  assign capture_s = run_dly_q && (report_in != {N_REPORTS{1'b0}});
  assign empty_s   = (wr_ptr_q == rd_ptr_q);
  assign full_s    = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                     (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
  assign pop_s      = !empty_s && out_ready;
  assign push_req_s = capture_s && !suppress_s;
  assign push_s     = push_req_s && (!full_s || pop_s);
  assign drop_s     = push_req_s && full_s && !pop_s;

  assign head_s     = mem_q[rd_ptr_q[IDX_W-1:0]];
  assign out_valid  = !empty_s;
  assign out_offset = head_s[ENTRY_W-1:N_REPORTS];
  assign out_vector = head_s[N_REPORTS-1:0];
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

`ifdef LTL_REPORT_DEDUP_EN
  logic [N_REPORTS-1:0] last_vec_q, last_vec_d;
  logic [OFFSET_W-1:0]  last_off_q, last_off_d;
  logic                 last_v_q, last_v_d;

  assign suppress_s = capture_s && last_v_q && (report_in == last_vec_q) &&
                      (off_dly_q == last_off_q + OFF_ONE);

  // Track the most recent capture; a zero report on a live symbol breaks the run.
  always_comb begin
    last_vec_d = last_vec_q;
    last_off_d = last_off_q;
    last_v_d   = last_v_q;
    if (capture_s) begin
      last_vec_d = report_in;
      last_off_d = off_dly_q;
      last_v_d   = 1'b1;
    end else if (run_dly_q) begin
      last_v_d   = 1'b0;
    end else begin
      last_v_d   = last_v_q;
    end
  end

  // Dedup state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_vec_q <= {N_REPORTS{1'b0}};
      last_off_q <= {OFFSET_W{1'b0}};
      last_v_q   <= 1'b0;
    end else begin
      last_vec_q <= last_vec_d;
      last_off_q <= last_off_d;
      last_v_q   <= last_v_d;
    end
  end
`else
  assign suppress_s = 1'b0;
`endif

  // Next-state for offset, alignment, pointers and drop status.
  always_comb begin
    sym_off_d    = run ? (sym_off_q + OFF_ONE) : sym_off_q;
    run_dly_d    = run;
    off_dly_d    = sym_off_q;
    wr_ptr_d     = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d     = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    // A drop in the same cycle as a clear wins and restarts the count at one.
    if (drop_s) begin
      overflow_d = 1'b1;
      if (clear_status) begin
        drop_count_d = DROP_ONE;
      end else if (drop_count_q == DROP_MAX) begin
        drop_count_d = DROP_MAX;
      end else begin
        drop_count_d = drop_count_q + DROP_ONE;
      end
    end else if (clear_status) begin
      overflow_d   = 1'b0;
      drop_count_d = {DROP_W{1'b0}};
    end else begin
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sym_off_q    <= {OFFSET_W{1'b0}};
      run_dly_q    <= 1'b0;
      off_dly_q    <= {OFFSET_W{1'b0}};
      wr_ptr_q     <= {(IDX_W + 1){1'b0}};
      rd_ptr_q     <= {(IDX_W + 1){1'b0}};
      overflow_q   <= 1'b0;
      drop_count_q <= {DROP_W{1'b0}};
    end else begin
      sym_off_q    <= sym_off_d;
      run_dly_q    <= run_dly_d;
      off_dly_q    <= off_dly_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Entry storage is never cleared; reset only discards it through the pointers.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= {off_dly_q, report_in};
    end else begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= mem_q[wr_ptr_q[IDX_W-1:0]];
    end
  end

endmodule

// File: doc/ltl_report_collector.md
# ltl_report_collector

Downstream stage for the per-cluster LTL automata. It timestamps report activity (the `active_state` outputs of report STEs) with the symbol offset that caused it and buffers each non-zero report vector in a small FIFO. Entries drain over a valid/ready stream to the monitor's report arbiter. It sits between one `Automata_*` instance and the cluster-level report mux, sharing that automaton's `clk`, `reset` and `run`.

## Interface

**Parameters**
- `N_REPORTS`, default 4: number of report lines from the automaton.
- `OFFSET_W`, default 32: width of the symbol offset counter.
- `FIFO_DEPTH`, default 8: entry count; must be a power of 2 and at least 2.
- `DROP_W`, default 16: width of the drop counter.

**Ports**
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `run` in 1: the same signal driving the automaton; high means a symbol is consumed this cycle.
- `report_in` in `N_REPORTS`: automaton report `active_state` lines, registered in the automaton.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: consumer accepts the head.
- `out_offset` out `OFFSET_W`: symbol offset of the head entry.
- `out_vector` out `N_REPORTS`: report vector of the head entry.
- `overflow` out 1: sticky; set when any entry is dropped.
- `drop_count` out `DROP_W`: dropped entries, saturating.
- `clear_status` in 1: clears `overflow` and `drop_count`.

## Operation

**Offset counter `sym_off`**
- Reset to 0.
- Increments by 1 on every cycle with `run`=1.
- Wraps modulo 2^`OFFSET_W` with no flag.

**Alignment stage**
- One register stage captures `run_d <= run` and `off_d <= sym_off`, i.e. the offset of the symbol consumed that cycle.
- The automaton's `report_in` reflects the symbol consumed one cycle earlier.
- In a cycle where `run_d`=1, `report_in` pairs with `off_d`.

**Capture**
- Capture when `run_d`=1 and `report_in` is non-zero.
- Entry = {`off_d`, `report_in`}.
- `report_in` is ignored when `run_d`=0.

**FIFO**
- Circular buffer with read/write pointers one bit wider than the index.
- Full when the indices are equal and the MSBs differ.
- Empty when the pointers are equal.

**Push while full**
- If `out_valid`&`out_ready` pops in the same cycle, the push is accepted.
- Otherwise the entry is dropped: `overflow` <= 1, and `drop_count` increments, saturating at 2^`DROP_W`-1.

**Pop**
- Occurs when `out_valid`&`out_ready`.
- Pushing and popping on the same cycle with the FIFO empty: no bypass. The new entry becomes visible next cycle.

**Status clear**
- `clear_status`=1 clears `overflow` and `drop_count`.
- If a drop happens in the same cycle, the drop wins: `overflow`=1 and `drop_count`=1.

**Reset**
- Synchronous; may be asserted at any point mid-stream.
- Pointers, `sym_off`, `run_d`, `off_d`, `overflow`, `drop_count` and the dedup state all return to 0.
- FIFO contents are discarded; storage itself is not cleared.

## Timing

**Reset values of outputs**
- `out_valid`=0, `overflow`=0, `drop_count`=0.
- `out_offset` and `out_vector` are don't-care while `out_valid`=0.

**Latency**
- Symbol consumed at cycle T (`run`=1), report visible on `report_in` at T+1, entry written at the end of T+1, `out_valid`=1 at T+2.
- Back-to-back symbols produce one entry per cycle.

**Handshake**
- Once `out_valid`=1, the head entry stays stable until the pop.
- `out_valid` never deasserts without a pop, except on `reset`.
- `out_ready` may be asserted with `out_valid` low; it has no effect.

**Throughput**
- One push and one pop per cycle sustained.
- All outputs are registered or driven directly from FIFO storage, with no combinational path from `report_in`.

## Configuration

**`LTL_REPORT_DEDUP_EN` defined**
- The block holds `last_vec`, `last_off` and `last_v` (reset to 0).
- A capture is suppressed when `last_v`=1, `report_in`==`last_vec` and `off_d`==`last_off`+1 (modulo 2^`OFFSET_W`).
- On every capture, pushed or suppressed, `last_vec`/`last_off` update to the current values and `last_v`=1.
- Any `run_d`=1 cycle with `report_in`=0 clears `last_v`.
- Suppressed captures never count as drops.
- Net effect: a run of identical report vectors yields only its first entry.

**Undefined**
- Every qualifying capture is pushed.
- No dedup registers are instantiated.

## Test plan

- **Basic capture:** reset, then `run`=1 for 5 cycles, with `report_in`=4'b0100 on the cycle after the third symbol → one entry {offset 2, 4'b0100}. `out_valid` rises 2 cycles after that symbol is consumed.
- **Fill and overflow:** `out_ready`=0; 10 consecutive non-zero captures with `FIFO_DEPTH`=8 → 8 entries with offsets 0..7, `overflow`=1, `drop_count`=2. Draining returns offsets 0..7 in order.
- **Push on full with pop:** FIFO full, `out_ready`=1 on the same cycle as a capture → no drop, and `drop_count` stays unchanged.
- **Wrap:** `OFFSET_W`=4, 20 symbols each reporting 4'b0001 → captured offsets run 0..15 then 0..3.
- **Reset mid-stream:** `reset` asserted for 1 cycle with 3 entries queued → next cycle `out_valid`=0, `overflow`=0, and the next capture carries offset 0.
- **Dedup** (`LTL_REPORT_DEDUP_EN`): `report_in`=4'b1000 on 4 consecutive symbols, then 0, then 4'b1000 → exactly 2 entries, at offsets 0 and 5. Without the macro: 5 entries.
